tx_framer_mod: RTL and testbench

- Transmit-side baseband framer/modulator; mirror of the rx chain, feeding the fmcomms DAC path.
- Accepts a payload byte stream and builds a frame: 32-bit unique-word preamble, length byte, payload, zero tail.
- QPSK-maps each dibit and zero-stuffs to SPS samples per symbol. Emits DAC samples on a strobed valid for a downstream SRRC interpolator.

---
 rtl/tx_framer_mod.sv | 235 +++++++++++++++++++++++
 tb/tb_tx_framer_mod.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer_mod.sv
// rtl/tx_framer_mod.sv - QPSK transmit framer: UW preamble, length header, payload, zero tail, zero-stuffed DAC samples
//
// Optional feature macro: TX_SCRAMBLER_EN (additive x^7+x^4+1 scrambler on payload bits only).
//
// Ports:
//   i_clk          DAC-rate clock
//   i_rst          synchronous active-high reset
//   i_ctrl[31:0]   bit0 = tx enable, remaining bits ignored
//   i_start        start-of-frame pulse, i_len sampled with it
//   i_len[7:0]     payload byte count
//   i_data[7:0]    payload byte, accepted on i_data_vld & o_data_rdy
//   i_data_vld     payload byte valid
//   o_data_rdy     one-byte holding register can take a byte
//   o_toDAC_i/q    12-bit signed sample sign-extended to 16, held between strobes
//   o_toDAC_vld    one-cycle sample strobe every CLKS_PER_SAMP clocks
//   o_busy         frame in progress
//   o_done         one-cycle pulse after the last tail sample
//   o_underrun     sticky, set when a payload byte was missing and 0x00 was sent
`timescale 1ns/1ps
module tx_framer_mod #(
    parameter int          SPS           = 4,
    parameter int          CLKS_PER_SAMP = 2,
    parameter int          AMP           = 1024,
    parameter logic [31:0] UW            = 32'hF35AC61D,
    parameter int          TAIL_SYMS     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ctrl,
    input  logic        i_start,
    input  logic [7:0]  i_len,
    input  logic [7:0]  i_data,
    input  logic        i_data_vld,
    output logic        o_data_rdy,
    output logic [15:0] o_toDAC_i,
    output logic [15:0] o_toDAC_q,
    output logic        o_toDAC_vld,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_TAIL = 3'd4;

    localparam logic [15:0] CLK_LAST  = 16'(CLKS_PER_SAMP - 1);
    localparam logic [15:0] SAMP_LAST = 16'(SPS - 1);
    localparam logic [7:0]  TAIL_LAST = 8'(TAIL_SYMS - 1);
    localparam logic [15:0] POS       = 16'(AMP);
    localparam logic [15:0] NEG       = 16'(-AMP);

    logic [2:0]  state;
    logic [15:0] clk_cnt;
    logic [15:0] samp_cnt;
    logic [7:0]  sym_cnt;
    logic [7:0]  byte_cnt;
    logic [7:0]  len_reg;
    logic [8:0]  fetch_cnt;
    logic [31:0] shreg;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic        fin;

    logic        start_ok;
    logic        accept;
    logic        emit;
    logic        sym_end;
    logic        take;
    logic [7:0]  raw_byte;
    logic [7:0]  pay_byte;
    logic        ctrl_unused;

    assign ctrl_unused = ^i_ctrl[31:1];

    assign o_busy     = (state != S_IDLE);
    assign start_ok   = (state == S_IDLE) && i_start && i_ctrl[0];
    assign o_data_rdy = ((state == S_HDR) || (state == S_PAY)) && !hold_full &&
                        (fetch_cnt < {1'b0, len_reg});
    assign accept     = i_data_vld && o_data_rdy;
    // fin marks the cycle after the last tail strobe; no sample is produced there.
    assign emit       = o_busy && !fin && (clk_cnt == 16'd0);
    assign sym_end    = emit && (samp_cnt == SAMP_LAST);
    // A new payload byte is loaded at the boundary into its first symbol.
    assign take       = sym_end && (sym_cnt == 8'd3) &&
                        (((state == S_HDR) && (len_reg != 8'd0)) ||
                         ((state == S_PAY) && (byte_cnt != len_reg - 8'd1)));
    assign raw_byte   = hold_full ? hold_data : 8'h00;

`ifdef TX_SCRAMBLER_EN
    logic [6:0] lfsr;
    logic [6:0] lfsr_next;
    logic       scr_fb;

    always_comb begin
        lfsr_next = lfsr;
        scr_fb    = 1'b0;
        pay_byte  = raw_byte;
        for (int b = 0; b < 8; b++) begin
            scr_fb                = lfsr_next[6] ^ lfsr_next[3];
            pay_byte[3'(7 - b)]   = raw_byte[3'(7 - b)] ^ scr_fb;
            lfsr_next             = {lfsr_next[5:0], scr_fb};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            lfsr <= 7'h7F;
        end else if (take) begin
            lfsr <= lfsr_next;
        end
    end
`else
    assign pay_byte = raw_byte;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            clk_cnt     <= 16'd0;
            samp_cnt    <= 16'd0;
            sym_cnt     <= 8'd0;
            byte_cnt    <= 8'd0;
            len_reg     <= 8'd0;
            fetch_cnt   <= 9'd0;
            shreg       <= 32'd0;
            hold_data   <= 8'd0;
            hold_full   <= 1'b0;
            fin         <= 1'b0;
            o_toDAC_i   <= 16'd0;
            o_toDAC_q   <= 16'd0;
            o_toDAC_vld <= 1'b0;
            o_done      <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            o_toDAC_vld <= 1'b0;
            o_done      <= 1'b0;
            // A missing byte still consumes its slot, so it counts as fetched.
            fetch_cnt   <= fetch_cnt + 9'(accept) + 9'(take & ~hold_full);
            if (accept) begin
                hold_data <= i_data;
                hold_full <= 1'b1;
            end

            if (state == S_IDLE) begin
                if (start_ok) begin
                    state      <= S_PRE;
                    shreg      <= UW;
                    len_reg    <= i_len;
                    clk_cnt    <= 16'd0;
                    samp_cnt   <= 16'd0;
                    sym_cnt    <= 8'd0;
                    byte_cnt   <= 8'd0;
                    fetch_cnt  <= 9'd0;
                    hold_full  <= 1'b0;
                    fin        <= 1'b0;
                    o_underrun <= 1'b0;
                end
            end else if (fin) begin
                state  <= S_IDLE;
                fin    <= 1'b0;
                o_done <= 1'b1;
            end else begin
                clk_cnt <= (clk_cnt == CLK_LAST) ? 16'd0 : clk_cnt + 16'd1;
                if (emit) begin
                    o_toDAC_vld <= 1'b1;
                    if ((samp_cnt == 16'd0) && (state != S_TAIL)) begin
                        o_toDAC_i <= shreg[31] ? NEG : POS;
                        o_toDAC_q <= shreg[30] ? NEG : POS;
                    end else begin
                        o_toDAC_i <= 16'd0;
                        o_toDAC_q <= 16'd0;
                    end
                    if (!sym_end) begin
                        samp_cnt <= samp_cnt + 16'd1;
                    end else begin
                        samp_cnt <= 16'd0;
                        case (state)
                            S_PRE: begin
                                if (sym_cnt == 8'd15) begin
                                    state   <= S_HDR;
                                    sym_cnt <= 8'd0;
                                    shreg   <= {len_reg, 24'h0};
                                end else begin
                                    sym_cnt <= sym_cnt + 8'd1;
                                    shreg   <= {shreg[29:0], 2'b00};
                                end
                            end
                            S_HDR: begin
                                if (sym_cnt == 8'd3) begin
                                    sym_cnt <= 8'd0;
                                    state   <= (len_reg == 8'd0) ? S_TAIL : S_PAY;
                                end else begin
                                    sym_cnt <= sym_cnt + 8'd1;
                                    shreg   <= {shreg[29:0], 2'b00};
                                end
                            end
                            S_PAY: begin
                                if (sym_cnt == 8'd3) begin
                                    sym_cnt <= 8'd0;
                                    if (byte_cnt == len_reg - 8'd1) begin
                                        state <= S_TAIL;
                                    end else begin
                                        byte_cnt <= byte_cnt + 8'd1;
                                    end
                                end else begin
                                    sym_cnt <= sym_cnt + 8'd1;
                                    shreg   <= {shreg[29:0], 2'b00};
                                end
                            end
                            default: begin
                                if (sym_cnt == TAIL_LAST) begin
                                    fin <= 1'b1;
                                end else begin
                                    sym_cnt <= sym_cnt + 8'd1;
                                end
                            end
                        endcase
                    end
                end
                if (take) begin
                    shreg <= {pay_byte, 24'h0};
                    if (hold_full) begin
                        hold_full <= 1'b0;
                    end else begin
                        o_underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_framer_mod.sv
// tb/tb_tx_framer_mod.sv - directed vector bench for tx_framer_mod
`timescale 1ns/1ps
module tb_tx_framer_mod;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_ctrl;
    logic        i_start;
    logic [7:0]  i_len;
    logic [7:0]  i_data;
    logic        i_data_vld;
    logic        o_data_rdy;
    logic [15:0] o_toDAC_i;
    logic [15:0] o_toDAC_q;
    logic        o_toDAC_vld;
    logic        o_busy;
    logic        o_done;
    logic        o_underrun;

    always #5 clk = ~clk;

    tx_framer_mod dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_ctrl      (i_ctrl),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_data      (i_data),
        .i_data_vld  (i_data_vld),
        .o_data_rdy  (o_data_rdy),
        .o_toDAC_i   (o_toDAC_i),
        .o_toDAC_q   (o_toDAC_q),
        .o_toDAC_vld (o_toDAC_vld),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_underrun  (o_underrun)
    );

    typedef struct {
        logic [7:0] len;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nsup;
        int         strobes;
        logic       underrun;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] uw = 32'hF35AC61D;

    logic [15:0] cap_i   [0:255];
    logic [15:0] cap_q   [0:255];
    int          cap_cyc [0:255];
    int          ncap = 0;
    int          ndone = 0;
    int          done_cyc = 0;
    logic        busy_at_done = 1'b1;
    int          cap_busy_bad = 0;

    logic [7:0]  feed_bytes [0:3];
    int          feed_n = 0;
    int          feed_idx = 0;
    logic        pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_toDAC_vld) begin
            if (ncap < 256) begin
                cap_i[ncap]   = o_toDAC_i;
                cap_q[ncap]   = o_toDAC_q;
                cap_cyc[ncap] = cyc;
            end
            if (!o_busy) cap_busy_bad = cap_busy_bad + 1;
            ncap = ncap + 1;
        end
        if (o_done) begin
            ndone        = ndone + 1;
            done_cyc     = cyc;
            busy_at_done = o_busy;
        end
    end

    // Byte source: inputs are stable from negedge to posedge, so vld&rdy seen
    // here is exactly the handshake taken at the following posedge.
    initial begin
        i_data_vld = 1'b0;
        i_data     = 8'h00;
        forever begin
            @(negedge clk);
            if (pend) feed_idx = feed_idx + 1;
            if (feed_idx < feed_n) begin
                i_data_vld = 1'b1;
                i_data     = feed_bytes[feed_idx];
            end else begin
                i_data_vld = 1'b0;
            end
            pend = i_data_vld && o_data_rdy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sym_iq(input logic [1:0] d);
        sym_iq = {(d[1] ? 16'hFC00 : 16'h0400), (d[0] ? 16'hFC00 : 16'h0400)};
    endfunction

    task automatic start_frame(input logic [7:0] len, input logic [7:0] b0, input logic [7:0] b1,
                               input int nsup, output int st);
        @(negedge clk);
        feed_bytes[0] = b0;
        feed_bytes[1] = b1;
        feed_n        = nsup;
        feed_idx      = 0;
        pend          = 1'b0;
        ncap          = 0;
        ndone         = 0;
        cap_busy_bad  = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = len;
        st      = cyc;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (ndone == 0 && n < budget) begin
            @(posedge clk);
            n = n + 1;
        end
        chk("done_timeout", 32'(ndone != 0), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input vec_t v, input int st);
        int          bad;
        int          last;
        logic [7:0]  b;
        logic [7:0]  hdr;
        chk({tag, ".strobes"}, 32'(ncap), 32'(v.strobes));
        chk({tag, ".done_cnt"}, 32'(ndone), 32'd1);
        chk({tag, ".busy_at_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, ".busy_strobes"}, 32'(cap_busy_bad), 32'd0);
        chk({tag, ".underrun"}, 32'(o_underrun), 32'(v.underrun));
        if (ncap > 0 && ncap <= 256) begin
            last = ncap - 1;
            chk({tag, ".first_lat"}, 32'(cap_cyc[0] - st), 32'd2);
            chk({tag, ".done_lat"}, 32'(done_cyc - cap_cyc[last]), 32'd1);
        end
        for (int s = 0; s < 16; s++)
            chk($sformatf("%s.pre%0d", tag, s), {cap_i[4*s], cap_q[4*s]}, sym_iq(uw[31-2*s -: 2]));
        hdr = v.len;
        for (int s = 0; s < 4; s++)
            chk($sformatf("%s.hdr%0d", tag, s), {cap_i[4*(16+s)], cap_q[4*(16+s)]}, sym_iq(hdr[7-2*s -: 2]));
        for (int k = 0; k < 32'(v.len); k++) begin
            b = (k == 0) ? v.e0 : v.e1;
            for (int s = 0; s < 4; s++)
                chk($sformatf("%s.pay%0d_%0d", tag, k, s),
                    {cap_i[4*(20+4*k+s)], cap_q[4*(20+4*k+s)]}, sym_iq(b[7-2*s -: 2]));
        end
        bad = 0;
        for (int k = 0; k < v.strobes; k++)
            if ((k % 4 != 0 || k >= 4*(20 + 4*32'(v.len))) && {cap_i[k], cap_q[k]} !== 32'd0)
                bad = bad + 1;
        chk({tag, ".zero_stuff"}, 32'(bad), 32'd0);
        bad = 0;
        for (int k = 1; k < v.strobes; k++)
            if (cap_cyc[k] - cap_cyc[k-1] != 2) bad = bad + 1;
        chk({tag, ".spacing"}, 32'(bad), 32'd0);
    endtask

    vec_t vecs [5];
    vec_t v;
    int   st;
    int   n;

    initial begin
`ifdef TX_SCRAMBLER_EN
        vecs[0] = '{8'd1, 8'h1B, 8'h00, 1, 112, 1'b0, 8'h15, 8'h00};
        vecs[1] = '{8'd2, 8'hFF, 8'h00, 1, 128, 1'b1, 8'hF1, 8'hF2};
        vecs[2] = '{8'd0, 8'h00, 8'h00, 0,  96, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'd1, 8'h00, 8'h00, 1, 112, 1'b0, 8'h0E, 8'h00};
        vecs[4] = '{8'd2, 8'hA5, 8'h3C, 2, 128, 1'b0, 8'hAB, 8'hCE};
`else
        vecs[0] = '{8'd1, 8'h1B, 8'h00, 1, 112, 1'b0, 8'h1B, 8'h00};
        vecs[1] = '{8'd2, 8'hFF, 8'h00, 1, 128, 1'b1, 8'hFF, 8'h00};
        vecs[2] = '{8'd0, 8'h00, 8'h00, 0,  96, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'd1, 8'h00, 8'h00, 1, 112, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{8'd2, 8'hA5, 8'h3C, 2, 128, 1'b0, 8'hA5, 8'h3C};
`endif
        i_rst   = 1'b1;
        i_ctrl  = 32'd1;
        i_start = 1'b0;
        i_len   = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst.vld",  32'(o_toDAC_vld), 32'd0);
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.done", 32'(o_done), 32'd0);
        chk("rst.urun", 32'(o_underrun), 32'd0);
        chk("rst.rdy",  32'(o_data_rdy), 32'd0);
        chk("rst.iq",   {o_toDAC_i, o_toDAC_q}, 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            start_frame(vecs[r].len, vecs[r].d0, vecs[r].d1, vecs[r].nsup, st);
            wait_done(1000);
            check_frame($sformatf("vec%0d", r), vecs[r], st);
        end

        // Start pulses while busy are ignored; enable dropping mid-frame has no effect.
        start_frame(8'd0, 8'h00, 8'h00, 0, st);
        repeat (20) @(negedge clk);
        i_start = 1'b1;
        i_len   = 8'd5;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        i_ctrl = 32'd0;
        wait_done(1000);
        repeat (20) @(negedge clk);
        v = '{8'd0, 8'h00, 8'h00, 0, 96, 1'b0, 8'h00, 8'h00};
        check_frame("busy_start", v, st);

        // Start with the enable low is ignored.
        ncap  = 0;
        ndone = 0;
        i_start = 1'b1;
        i_len   = 8'd1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("dis.busy", 32'(o_busy), 32'd0);
        chk("dis.strobes", 32'(ncap), 32'd0);
        chk("dis.done", 32'(ndone), 32'd0);
        i_ctrl = 32'hFFFF_FFF1;

        // Reset in the middle of the payload.
        start_frame(8'd3, 8'h12, 8'h34, 2, st);
        n = 0;
        while (ncap < 90 && n < 1000) begin
            @(posedge clk);
            n = n + 1;
        end
        chk("mid.reach", 32'(ncap >= 90), 32'd1);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        chk("mid.vld",  32'(o_toDAC_vld), 32'd0);
        chk("mid.busy", 32'(o_busy), 32'd0);
        chk("mid.iq",   {o_toDAC_i, o_toDAC_q}, 32'd0);
        chk("mid.rdy",  32'(o_data_rdy), 32'd0);
        chk("mid.done", 32'(o_done), 32'd0);
        chk("mid.urun", 32'(o_underrun), 32'd0);
        i_rst = 1'b0;
        repeat (3) @(negedge clk);
        start_frame(8'd0, 8'h00, 8'h00, 0, st);
        wait_done(1000);
        v = '{8'd0, 8'h00, 8'h00, 0, 96, 1'b0, 8'h00, 8'h00};
        check_frame("post_rst", v, st);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
